// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the instruction fetch stage: sequential fetch,
// stall/back-pressure, redirect with slot flush, HALT detection, one IF slot to decode.
module fetch_sequencer #(
  parameter int unsigned          PC_W      = 9,
  parameter int unsigned          INSTR_W   = 32,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   HALT_WORD = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               if_ready,
  output logic               halted,
  output logic               pc_wrapped,
  output logic [15:0]        fetch_count
);

  localparam int unsigned CNT_W = 16;
  localparam logic [PC_W-1:0]  PC_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic               halted_q, halted_d;
  logic               pc_wrapped_q, pc_wrapped_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

  logic step_c;
  logic xfer_c;

  assign xfer_c = if_valid_q && if_ready;
  assign step_c = (state_q == S_RUN) && !stall && (!if_valid_q || if_ready);

  // Next-state and slot update; redirect outranks stall and halt detection.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    halted_d      = halted_q;
    pc_wrapped_d  = pc_wrapped_q;
    fetch_count_d = fetch_count_q;

    if (xfer_c && (fetch_count_q != CNT_MAX)) begin
      fetch_count_d = fetch_count_q + CNT_W'(1);
    end

    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_RUN;
      end
    end else if (redirect_valid) begin
      state_d    = S_RUN;
      halted_d   = 1'b0;
      pc_d       = redirect_target;
      if_valid_d = 1'b0;
    end else if (step_c) begin
      if_instr_d = imem_rdata;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + PC_W'(1);
      if (pc_q == PC_MAX) begin
        pc_wrapped_d = 1'b1;
      end
      if (imem_rdata == HALT_WORD) begin
        state_d  = S_HALT;
        halted_d = 1'b1;
      end
    end else if (if_ready) begin
      // Slot consumed with nothing to refill (stalled, or halted).
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      halted_q      <= 1'b0;
      pc_wrapped_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      halted_q      <= halted_d;
      pc_wrapped_q  <= pc_wrapped_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc          = pc_q;
  assign if_valid    = if_valid_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign halted      = halted_q;
  assign pc_wrapped  = pc_wrapped_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the program counter that drives the instruction_fetch datapath (512-word instruction memory, 9-bit PC, 32-bit word, combinational read).
- Fetches sequentially, honours stalls and decode back-pressure, and applies branch/jump redirects with a one-slot flush.
- Detects a HALT word and stops fetching.
- Presents one registered instruction slot (valid/ready) to decode.

Parameters:
- PC_W, 9, PC/address width; the memory holds 2**PC_W words.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, encoding that stops fetch.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start  in  1  one-cycle pulse; leaves IDLE.
- stall  in  1  freeze PC and the IF slot (hazard/external stall).
- redirect_valid  in  1  branch/jump taken.
- redirect_target  in  PC_W  new PC.
- imem_rdata  in  INSTR_W  word from instruction_fetch at pc (same-cycle combinational).
- pc  out  PC_W  address driven to instruction_fetch.
- if_valid  out  1  IF slot holds an instruction.
- if_instr  out  INSTR_W  instruction in the IF slot.
- if_pc  out  PC_W  address of if_instr.
- if_ready  in  1  decode accepts the slot this cycle.
- halted  out  1  high in HALT.
- pc_wrapped  out  1  sticky; set when PC wraps from 2**PC_W-1 to 0.
- fetch_count  out  16  number of instructions accepted by decode; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE, pc = RESET_PC.
  - if_valid, halted, pc_wrapped = 0; fetch_count = 0; if_instr = 0; if_pc = 0.
  - Reset mid-operation drops any in-flight slot with no handshake.
- States: IDLE, RUN, HALT.
- IDLE:
  - No fetch; pc holds.
  - start=1 -> RUN next cycle.
  - redirect_valid is ignored.
- RUN, step condition = !stall && (!if_valid || if_ready):
  - If the step condition holds, on the clock edge: if_instr <= imem_rdata; if_pc <= pc; if_valid <= 1; pc <= pc+1 (mod 2**PC_W).
  - Latency: the word at address A is on if_instr one cycle after pc=A.
  - Step condition false and if_ready=1: if_valid <= 0 (slot consumed, nothing refilled).
  - Step condition false and if_ready=0: everything holds.
  - Handshake: transfer occurs when if_valid && if_ready. When transferred, fetch_count increments.
  - Once if_valid=1, if_instr and if_pc are stable until transfer.
- Wrap: a step with pc = 2**PC_W-1 loads pc = 0 and sets pc_wrapped (sticky until reset).
- Redirect (RUN or HALT):
  - Highest priority and overrides stall.
  - pc <= redirect_target; if_valid <= 0, flushing the wrong-path slot.
  - A transfer in the same cycle (if_valid && if_ready) still counts.
  - The first redirected word appears on if_instr on the second edge after the redirect.
  - From HALT, a redirect returns to RUN and clears halted.
- Halt detect:
  - When a step latches imem_rdata == HALT_WORD, the slot is loaded normally and pc still increments.
  - State -> HALT; halted=1 on the same edge.
- HALT:
  - No further steps; pc holds.
  - The HALT slot is still delivered once through the handshake, then if_valid=0.
  - stall and start are ignored.
- Simultaneous events:
  - Redirect with a HALT_WORD fetch in the same cycle: the redirect wins and no halt occurs.
  - Redirect with stall: the redirect is applied.
  - start while in RUN or HALT: ignored.
- fetch_count stops at 16'hFFFF.

Test Plan:
- Reset low, release, pulse start, if_ready=1, memory holds word i at address i -> if_instr = 0,1,2,... on consecutive cycles; if_pc tracks; fetch_count = 5 after 5 transfers.
- RUN with stall=1 for 3 cycles at pc=4 -> pc stays 4 and the slot is unchanged; after stall=0, the next slot is word 4.
- if_ready=0 while if_valid=1 for 4 cycles -> if_instr/if_pc constant and pc frozen; fetch_count does not increment until ready.
- redirect_valid=1, target=9'h1F0, during stall at pc=7 -> if_valid=0 next cycle, pc=0x1F0, then if_pc=0x1F0; the wrong-path word is never transferred.
- HALT_WORD placed at address 3 -> words 0..3 delivered, halted=1, pc=4 held indefinitely; redirect to 0 resumes with halted=0.
- Redirect to 0x1FE, run 3 steps -> pc sequence 0x1FE, 0x1FF, 0x000, pc_wrapped=1; assert reset=0 mid-stream -> all outputs cleared immediately (asynchronously).
